// File: rtl/tx_metaframer.sv
// Interlaken TX meta-framer: wraps user words into fixed-length meta-frames
// (sync, scrambler state, skip, payload, diagnostic) with idle fill.
module tx_metaframer #(
    parameter int META_FRAME_LEN = 16,
    parameter int SCRAM_W        = 58
) (
    input  logic               USER_CLK,
    input  logic               SYSTEM_RESET,
    input  logic               ENABLE,
    input  logic [63:0]        S_DATA,
    input  logic [1:0]         S_HEADER,
    input  logic               S_VALID,
    output logic               S_READY,
    input  logic [SCRAM_W-1:0] SCRAM_STATE,
    input  logic [1:0]         STATUS_IN,
    output logic [63:0]        DATA_OUT,
    output logic [1:0]         HEADER_OUT,
    output logic               DATA_TO_SEND,
    output logic               FRAME_START
);

    localparam int                POS_W    = $clog2(META_FRAME_LEN);
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(META_FRAME_LEN - 1);
    localparam logic [63:0]       SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
    localparam logic [63:0]       SKIP_WORD = 64'h1E1E_1E1E_1E1E_1E1E;
    localparam logic [63:0]       IDLE_WORD = 64'h0700_0000_0000_0000;
    localparam logic [1:0]        HDR_CTRL  = 2'b10;

    typedef enum logic [1:0] {
        OFF,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_next, slot_mode;
    logic [POS_W-1:0] pos;
    logic             payload, last;
    logic [63:0]      word_next;
    logic [1:0]       hdr_next;

    // slot_mode is how the slot generated this cycle behaves: OFF->RUN emits
    // the sync word immediately, and a falling ENABLE turns the current slot
    // into a drain slot.
    always_comb begin
        payload    = (pos >= POS_W'(3)) && (pos != LAST_POS);
        last       = (pos == LAST_POS);
        slot_mode  = state;
        case (state)
            OFF:     if (ENABLE)  slot_mode = RUN;
            RUN:     if (!ENABLE) slot_mode = DRAIN;
            default: slot_mode = state;
        endcase

        S_READY    = (state == RUN) && ENABLE && payload && !SYSTEM_RESET;

        state_next = slot_mode;
        if ((slot_mode == DRAIN) && last)
            state_next = ENABLE ? RUN : OFF;

        word_next  = IDLE_WORD;
        hdr_next   = HDR_CTRL;
        if (pos == '0) begin
            word_next = SYNC_WORD;
        end else if (pos == POS_W'(1)) begin
            word_next = {6'b001010, 58'(SCRAM_STATE)};
        end else if (pos == POS_W'(2)) begin
            word_next = SKIP_WORD;
        end else if (last) begin
            word_next = {6'b011001, 24'd0, STATUS_IN, 32'd0};
        end else if (S_VALID && S_READY) begin
            word_next = S_DATA;
            hdr_next  = S_HEADER;
        end
    end

    // Output register stage
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state        <= OFF;
            pos          <= '0;
            DATA_OUT     <= '0;
            HEADER_OUT   <= '0;
            DATA_TO_SEND <= 1'b0;
            FRAME_START  <= 1'b0;
        end else begin
            state <= state_next;
            if (slot_mode != OFF) begin
                pos          <= last ? '0 : pos + POS_W'(1);
                DATA_OUT     <= word_next;
                HEADER_OUT   <= hdr_next;
                DATA_TO_SEND <= 1'b1;
                FRAME_START  <= (pos == '0);
            end else begin
                pos          <= '0;
                DATA_OUT     <= '0;
                HEADER_OUT   <= '0;
                DATA_TO_SEND <= 1'b0;
                FRAME_START  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_metaframer.sv
// Scoreboard bench for tx_metaframer: directed stimulus pushes expected
// framed words; a negedge monitor pops and compares each valid output.
module tb_tx_metaframer;

    localparam logic [63:0] SYNC   = 64'h78F6_78F6_78F6_78F6;
    localparam logic [63:0] SKIP   = 64'h1E1E_1E1E_1E1E_1E1E;
    localparam logic [63:0] IDLE   = 64'h0700_0000_0000_0000;
    localparam logic [63:0] SCRAM0 = 64'h2800_0000_0000_0000;
    localparam logic [63:0] DIAG1  = 64'h6400_0001_0000_0000;

    logic        USER_CLK = 1'b0;
    logic        SYSTEM_RESET;
    logic        ENABLE;
    logic [63:0] S_DATA;
    logic [1:0]  S_HEADER;
    logic        S_VALID;
    logic        S_READY;
    logic [57:0] SCRAM_STATE;
    logic [1:0]  STATUS_IN;
    logic [63:0] DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        DATA_TO_SEND;
    logic        FRAME_START;

    always #5 USER_CLK = ~USER_CLK;

    tx_metaframer #(.META_FRAME_LEN(16), .SCRAM_W(58)) dut (
        .USER_CLK     (USER_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .ENABLE       (ENABLE),
        .S_DATA       (S_DATA),
        .S_HEADER     (S_HEADER),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .SCRAM_STATE  (SCRAM_STATE),
        .STATUS_IN    (STATUS_IN),
        .DATA_OUT     (DATA_OUT),
        .HEADER_OUT   (HEADER_OUT),
        .DATA_TO_SEND (DATA_TO_SEND),
        .FRAME_START  (FRAME_START)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  h;
        logic        fs;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] cur_data;

    function automatic void push(input logic [63:0] d, input logic [1:0] h);
        exp_t e;
        e.d  = d;
        e.h  = h;
        e.fs = (d == SYNC) && (h == 2'b10);
        exp_q.push_back(e);
    endfunction

    function automatic void push_head(input logic [63:0] scram_word);
        push(SYNC, 2'b10);
        push(scram_word, 2'b10);
        push(SKIP, 2'b10);
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) push(IDLE, 2'b10);
    endfunction

    function automatic void push_data(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) push(first + 64'(i), 2'b01);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge USER_CLK) begin
        if (DATA_TO_SEND === 1'b1) begin
            exp_t a, e;
            a.d  = DATA_OUT;
            a.h  = HEADER_OUT;
            a.fs = FRAME_START;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got %h/%b/%b expected nothing", a.d, a.h, a.fs);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL stream got %h/%b/%b expected %h/%b/%b",
                             a.d, a.h, a.fs, e.d, e.h, e.fs);
                end
            end
        end
    end

    task automatic drive(input int ncyc, input logic [31:0] en_m, input logic [31:0] vld_m,
                         input logic [31:0] rdy_m, input logic [31:0] rst_m,
                         input logic [57:0] scram, input logic [1:0] status,
                         input logic [1:0] hdr_alt, input logic rst_after);
        logic acc;
        acc = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge USER_CLK); #1;
            if (acc) cur_data = cur_data + 64'd1;
            ENABLE       = en_m[c];
            S_VALID      = vld_m[c];
            SYSTEM_RESET = rst_m[c];
            S_DATA       = cur_data;
            S_HEADER     = cur_data[0] ? hdr_alt : 2'b01;
            SCRAM_STATE  = ((c % 16) == 1) ? scram : 58'h155_5555_5555_5555;
            STATUS_IN    = ((c % 16) == 15) ? status : ~status;
            @(negedge USER_CLK);
            chk($sformatf("s_ready_c%0d", c), {63'd0, S_READY}, {63'd0, rdy_m[c]});
            acc = S_READY && S_VALID;
        end
        @(posedge USER_CLK); #1;
        if (acc) cur_data = cur_data + 64'd1;
        ENABLE       = 1'b0;
        S_VALID      = 1'b0;
        SYSTEM_RESET = rst_after;
    endtask

    task automatic end_check(input string name);
        @(posedge USER_CLK); #1;
        @(negedge USER_CLK);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_dts_low"}, {63'd0, DATA_TO_SEND}, 64'd0);
        chk({name, "_data_zero"}, DATA_OUT, 64'd0);
        chk({name, "_hdr_zero"}, {62'd0, HEADER_OUT}, 64'd0);
        chk({name, "_fs_low"}, {63'd0, FRAME_START}, 64'd0);
        chk({name, "_ready_low"}, {63'd0, S_READY}, 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        SYSTEM_RESET = 1'b1;
        ENABLE       = 1'b1;
        S_DATA       = '0;
        S_HEADER     = 2'b01;
        S_VALID      = 1'b1;
        SCRAM_STATE  = '0;
        STATUS_IN    = 2'b00;
        cur_data     = '0;
        repeat (3) @(posedge USER_CLK);
        #1;
        S_VALID = 1'b0;
        end_check("reset");
        SYSTEM_RESET = 1'b0;
        ENABLE       = 1'b0;

        // Idle frames only
        push_head(SCRAM0); push_idle(12); push(DIAG1, 2'b10);
        push_head(SCRAM0); push_idle(12); push(DIAG1, 2'b10);
        drive(32, 32'h0001_FFFF, 32'h0, 32'h0000_7FF8, 32'h0, 58'd0, 2'b01, 2'b01, 1'b0);
        end_check("idle");

        // Continuous stream across two frames
        cur_data = 64'd0;
        push_head(SCRAM0); push_data(64'd0, 12);  push(DIAG1, 2'b10);
        push_head(SCRAM0); push_data(64'd12, 12); push(DIAG1, 2'b10);
        drive(32, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FF8_7FF8, 32'h0, 58'd0, 2'b01, 2'b01, 1'b0);
        chk("stream_count", cur_data, 64'd24);
        end_check("stream");

        // Scrambler and status fields
        push(SYNC, 2'b10); push(64'h2AAA_AAAA_AAAA_AAAA, 2'b10); push(SKIP, 2'b10);
        push_idle(12); push(64'h6400_0003_0000_0000, 2'b10);
        drive(16, 32'h1, 32'h0, 32'h0, 32'h0, 58'h2AA_AAAA_AAAA_AAAA, 2'b11, 2'b01, 1'b0);
        end_check("fields");

        // ENABLE drop at pos 6, re-raised during drain
        cur_data = 64'd100;
        push_head(SCRAM0); push_data(64'd100, 3); push_idle(9); push(DIAG1, 2'b10);
        push_head(SCRAM0); push_data(64'd103, 12); push(DIAG1, 2'b10);
        drive(32, 32'h7FFF_FC3F, 32'hFFFF_FFFF, 32'h7FF8_0038, 32'h0, 58'd0, 2'b01, 2'b01, 1'b0);
        chk("drain_count", cur_data, 64'd115);
        end_check("drain");

        // Reset mid-frame at pos 9
        push_head(SCRAM0); push_idle(6);
        drive(10, 32'h3FF, 32'h0, 32'h1F8, 32'h200, 58'd0, 2'b01, 2'b01, 1'b1);
        end_check("midreset");
        push_head(SCRAM0); push_idle(12); push(DIAG1, 2'b10);
        drive(16, 32'h1, 32'h0, 32'h0, 32'h0, 58'd0, 2'b01, 2'b01, 1'b0);
        end_check("after_reset");

        // Valid toggling every other cycle; odd words carry header 11
        cur_data = 64'd200;
        push_head(SCRAM0);
        for (int k = 0; k < 6; k++) begin
            push(IDLE, 2'b10);
            push(64'd200 + 64'(k), (k % 2 == 1) ? 2'b11 : 2'b01);
        end
        push(DIAG1, 2'b10);
        drive(16, 32'h7FFF, 32'h5555, 32'h7FF8, 32'h0, 58'd0, 2'b01, 2'b11, 1'b0);
        chk("stall_count", cur_data, 64'd206);
        end_check("stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
